// File: rtl/tl_rx_error_report_ctrl_pkg.sv
// Shared definitions for the RX error report controller: error codes, severity
// mapping, PCIe error-message codes and the control part of the job record.
package tl_rx_error_report_ctrl_pkg;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_OVERFLOW  = 3'd1,
    ERR_FC        = 3'd2,
    ERR_MALFORMED = 3'd3,
    ERR_ECRC      = 3'd4,
    ERR_UR        = 3'd5,
    ERR_UNEXP_CPL = 3'd6,
    ERR_POISONED  = 3'd7
  } err_type_e;

  typedef enum logic [1:0] {
    SEV_COR      = 2'd0,
    SEV_NONFATAL = 2'd1,
    SEV_FATAL    = 2'd2
  } sev_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } tx_state_e;

  localparam logic [7:0] MSG_ERR_COR      = 8'h30;
  localparam logic [7:0] MSG_ERR_NONFATAL = 8'h31;
  localparam logic [7:0] MSG_ERR_FATAL    = 8'h33;

  // Job record is {is_cpl, msg_code[7:0], req_id, tag}; this is the is_cpl + msg_code part.
  localparam int JOB_CTRL_W = 9;

  function automatic sev_e severity_of(input logic [2:0] err_type);
    case (err_type)
      ERR_OVERFLOW, ERR_FC, ERR_MALFORMED: return SEV_FATAL;
      default:                             return SEV_NONFATAL;
    endcase
  endfunction

  function automatic logic [7:0] msg_code_of(input sev_e sev);
    case (sev)
      SEV_FATAL:    return MSG_ERR_FATAL;
      SEV_NONFATAL: return MSG_ERR_NONFATAL;
      default:      return MSG_ERR_COR;
    endcase
  endfunction

  // Enable vector is ordered {fatal, nonfatal, cor}.
  function automatic logic report_enabled(input sev_e sev, input logic [2:0] en);
    case (sev)
      SEV_FATAL:    return en[2];
      SEV_NONFATAL: return en[1];
      default:      return en[0];
    endcase
  endfunction

endpackage

// File: rtl/tl_rx_error_report_ctrl_if.sv
// Job handshake between the error report controller (master) and the TX arbiter (slave).
interface tl_rx_error_report_ctrl_if #(
  parameter int RID_W = 16,
  parameter int TAG_W = 10
);
  logic             o_tx_req;
  logic             o_tx_is_cpl;
  logic [7:0]       o_tx_msg_code;
  logic [RID_W-1:0] o_tx_cpl_req_id;
  logic [TAG_W-1:0] o_tx_cpl_tag;
  logic             i_tx_grant;

  modport master (
    output o_tx_req, o_tx_is_cpl, o_tx_msg_code, o_tx_cpl_req_id, o_tx_cpl_tag,
    input  i_tx_grant
  );

  modport slave (
    input  o_tx_req, o_tx_is_cpl, o_tx_msg_code, o_tx_cpl_req_id, o_tx_cpl_tag,
    output i_tx_grant
  );
endinterface

// File: rtl/tl_rx_error_job_fifo.sv
// Two-write/one-read synchronous job FIFO; write port 1 is only used together with
// write port 0 and lands in the slot after it.
module tl_rx_error_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic                     i_clk,
  input  logic                     i_n_rst,
  input  logic                     i_wr0_en,
  input  logic [WIDTH-1:0]         i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [WIDTH-1:0]         i_wr1_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_free
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_wptr_p1;
  logic [AW:0]      w_wr_inc;
  logic             w_full;

  assign w_wptr_p1 = r_wptr + {{AW{1'b0}}, 1'b1};
  assign w_wr_inc  = i_wr1_en ? (AW+1)'(2) : {{AW{1'b0}}, i_wr0_en};
  // The extra pointer bit distinguishes a full queue from an empty one.
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_free    = w_full ? '0 : ((AW+1)'(DEPTH) - o_count);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_wr0_en) r_mem[r_wptr[AW-1:0]]    <= i_wr0_data;
    if (i_wr1_en) r_mem[w_wptr_p1[AW-1:0]] <= i_wr1_data;
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + w_wr_inc;
      if (i_rd_en) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/tl_rx_error_report_ctrl.sv
// RX error report controller: severity decode, sticky status, first-error header log,
// job queueing and the req/grant hand-off of error messages and UR completions to TX.
module tl_rx_error_report_ctrl
  import tl_rx_error_report_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH          = 4,
  parameter int REQUESTER_ID_WIDTH  = 16,
  parameter int REQUESTER_TAG_WIDTH = 10,
  parameter int HDR_LOG_WIDTH       = 128
) (
  input  logic                           i_clk,
  input  logic                           i_n_rst,
  input  logic                           i_error_check,
  input  logic [2:0]                     i_error_type,
  input  logic                           i_nonposted,
  input  logic [REQUESTER_ID_WIDTH-1:0]  i_rx_req_id,
  input  logic [REQUESTER_TAG_WIDTH-1:0] i_rx_req_tag,
  input  logic [HDR_LOG_WIDTH-1:0]       i_hdr_fields,
  input  logic [2:0]                     i_cfg_report_en,
  input  logic [7:0]                     i_status_clr,
  tl_rx_error_report_ctrl_if.master      tx_if,
  output logic [7:0]                     o_err_status,
  output logic [HDR_LOG_WIDTH-1:0]       o_hdr_log,
  output logic                           o_hdr_log_valid
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int JOB_W = JOB_CTRL_W + REQUESTER_ID_WIDTH + REQUESTER_TAG_WIDTH;

  tx_state_e          r_state;
  tx_state_e          w_state_nxt;
  logic [JOB_W-1:0]   r_job;
  logic [JOB_W-1:0]   w_head;
  logic [JOB_W-1:0]   w_cpl_job;
  logic [JOB_W-1:0]   w_msg_job;
  logic [JOB_W-1:0]   w_wr0_data;
  logic [AW:0]        w_count;
  logic [AW:0]        w_free;
  logic [AW:0]        w_free_eff;
  logic               w_err_valid;
  logic               w_need_cpl;
  logic               w_need_msg;
  logic               w_wr0_en;
  logic               w_wr1_en;
  logic               w_overflow;
  logic               w_pop;
  logic               w_load;
  sev_e               w_sev;
  logic [7:0]         r_status;
  logic [7:0]         w_status_set;
  logic [7:0]         w_status_nxt;
  logic               w_log_clr;
  logic               r_log_valid;
  logic [HDR_LOG_WIDTH-1:0] r_hdr_log;

  assign w_err_valid = i_error_check && (i_error_type != ERR_NONE);
  assign w_sev       = severity_of(i_error_type);
  assign w_need_cpl  = w_err_valid && (i_error_type == ERR_UR) && i_nonposted;
  assign w_need_msg  = w_err_valid && report_enabled(w_sev, i_cfg_report_en);
  assign w_cpl_job   = {1'b1, 8'h00, i_rx_req_id, i_rx_req_tag};
  assign w_msg_job   = {1'b0, msg_code_of(w_sev),
                        {REQUESTER_ID_WIDTH{1'b0}}, {REQUESTER_TAG_WIDTH{1'b0}}};

  // A pop this cycle frees a slot for a same-cycle push; pushes are kept in order,
  // so with one free slot only the first job (the completion, if any) survives.
  assign w_pop      = (r_state == ST_REQ) && tx_if.i_tx_grant;
  assign w_free_eff = w_free + {{AW{1'b0}}, w_pop};
  assign w_wr0_en   = (w_need_cpl || w_need_msg) && (w_free_eff != '0);
  assign w_wr1_en   = w_need_cpl && w_need_msg && (w_free_eff >= (AW+1)'(2));
  assign w_wr0_data = w_need_cpl ? w_cpl_job : w_msg_job;
  assign w_overflow = (w_need_cpl && w_need_msg) ? !w_wr1_en
                                                 : ((w_need_cpl || w_need_msg) && !w_wr0_en);

  tl_rx_error_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (JOB_W)
  ) u_job_fifo (
    .i_clk      (i_clk),
    .i_n_rst    (i_n_rst),
    .i_wr0_en   (w_wr0_en),
    .i_wr0_data (w_wr0_data),
    .i_wr1_en   (w_wr1_en),
    .i_wr1_data (w_msg_job),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_head),
    .o_count    (w_count),
    .o_free     (w_free)
  );

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Granting always returns to IDLE, which leaves one bubble cycle between jobs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_count != '0) begin
        w_state_nxt = ST_REQ;
        w_load      = 1'b1;
      end
      ST_REQ:  if (tx_if.i_tx_grant) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst)    r_job <= '0;
    else if (w_load) r_job <= w_head;
    else if (w_pop)  r_job <= '0;
  end

  assign tx_if.o_tx_req        = (r_state == ST_REQ);
  assign tx_if.o_tx_is_cpl     = r_job[JOB_W-1];
  assign tx_if.o_tx_msg_code   = r_job[JOB_W-2 -: 8];
  assign tx_if.o_tx_cpl_req_id = r_job[REQUESTER_TAG_WIDTH +: REQUESTER_ID_WIDTH];
  assign tx_if.o_tx_cpl_tag    = r_job[REQUESTER_TAG_WIDTH-1:0];

  // New set bits win over a same-cycle clear; clearing every error bit also frees the log.
  assign w_status_set = {7'b0, w_overflow} | (w_err_valid ? (8'd1 << i_error_type) : 8'd0);
  assign w_status_nxt = (r_status & ~i_status_clr) | w_status_set;
  assign w_log_clr    = (|i_status_clr[7:1]) && !(|w_status_nxt[7:1]);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_status    <= '0;
      r_log_valid <= 1'b0;
      r_hdr_log   <= '0;
    end else begin
      r_status <= w_status_nxt;
      if (w_err_valid && !r_log_valid) begin
        r_log_valid <= 1'b1;
        r_hdr_log   <= i_hdr_fields;
      end else if (w_log_clr) begin
        r_log_valid <= 1'b0;
      end
    end
  end

  assign o_err_status    = r_status;
  assign o_hdr_log       = r_hdr_log;
  assign o_hdr_log_valid = r_log_valid;

endmodule

// File: tb/tb_tl_rx_error_report_ctrl.sv
// Bench for tl_rx_error_report_ctrl: directed scenarios plus random error traffic,
// checked by a scoreboard fed from a queue-level reference model.
module tb_tl_rx_error_report_ctrl;
  localparam int DEPTH = 4;
  localparam int RID_W = 16;
  localparam int TAG_W = 10;
  localparam int HDR_W = 128;

  typedef struct {
    logic             isCpl;
    logic [7:0]       code;
    logic [RID_W-1:0] id;
    logic [TAG_W-1:0] tag;
  } job_t;

  logic             clk         = 1'b0;
  logic             nRst        = 1'b0;
  logic             errorCheck  = 1'b0;
  logic [2:0]       errorType   = '0;
  logic             nonposted   = 1'b0;
  logic [RID_W-1:0] rxReqId     = '0;
  logic [TAG_W-1:0] rxReqTag    = '0;
  logic [HDR_W-1:0] hdrFields   = '0;
  logic [2:0]       reportEn    = '0;
  logic [7:0]       statusClr   = '0;
  logic [7:0]       errStatus;
  logic [HDR_W-1:0] hdrLog;
  logic             hdrLogValid;

  job_t             expQ[$];
  logic [7:0]       mStatus   = '0;
  logic             mLogValid = 1'b0;
  logic [HDR_W-1:0] mLog      = '0;
  int               checks    = 0;
  int               failures  = 0;
  int               popCount  = 0;
  int               grantMode = 0;

  tl_rx_error_report_ctrl_if #(.RID_W(RID_W), .TAG_W(TAG_W)) txIf ();

  tl_rx_error_report_ctrl #(
    .FIFO_DEPTH          (DEPTH),
    .REQUESTER_ID_WIDTH  (RID_W),
    .REQUESTER_TAG_WIDTH (TAG_W),
    .HDR_LOG_WIDTH       (HDR_W)
  ) dut (
    .i_clk           (clk),
    .i_n_rst         (nRst),
    .i_error_check   (errorCheck),
    .i_error_type    (errorType),
    .i_nonposted     (nonposted),
    .i_rx_req_id     (rxReqId),
    .i_rx_req_tag    (rxReqTag),
    .i_hdr_fields    (hdrFields),
    .i_cfg_report_en (reportEn),
    .i_status_clr    (statusClr),
    .tx_if           (txIf),
    .o_err_status    (errStatus),
    .o_hdr_log       (hdrLog),
    .o_hdr_log_valid (hdrLogValid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  // Reference model: one step of the queue/status/log rules per clock edge.
  task automatic modelCycle();
    logic [7:0] setBits;
    logic [7:0] nextStatus;
    logic       fatal;
    job_t       j;
    setBits = '0;
    if (errorCheck && errorType != 3'd0) begin
      fatal = (errorType <= 3'd3);
      setBits[errorType] = 1'b1;
      if (errorType == 3'd5 && nonposted) begin
        j.isCpl = 1'b1; j.code = 8'h00; j.id = rxReqId; j.tag = rxReqTag;
        if (expQ.size() < DEPTH) expQ.push_back(j);
        else setBits[0] = 1'b1;
      end
      if (fatal ? reportEn[2] : reportEn[1]) begin
        j.isCpl = 1'b0; j.code = fatal ? 8'h33 : 8'h31; j.id = '0; j.tag = '0;
        if (expQ.size() < DEPTH) expQ.push_back(j);
        else setBits[0] = 1'b1;
      end
    end
    nextStatus = (mStatus & ~statusClr) | setBits;
    if (errorCheck && errorType != 3'd0 && !mLogValid) begin
      mLogValid = 1'b1;
      mLog      = hdrFields;
    end else if (statusClr[7:1] != 7'd0 && nextStatus[7:1] == 7'd0) begin
      mLogValid = 1'b0;
    end
    mStatus = nextStatus;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge nRst);
      if (!nRst) begin
        expQ.delete();
        mStatus   = '0;
        mLogValid = 1'b0;
        mLog      = '0;
      end else begin
        modelCycle();
      end
    end
  end

  // Arbiter and monitor: drives grant, pops the scoreboard on each handshake.
  initial begin
    logic g;
    logic lastHandshake;
    job_t e;
    lastHandshake   = 1'b0;
    txIf.i_tx_grant = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      checkOutput("err_status", 128'(errStatus), 128'(mStatus));
      checkOutput("hdr_log_valid", 128'(hdrLogValid), 128'(mLogValid));
      if (mLogValid) checkOutput("hdr_log", hdrLog, mLog);
      if (lastHandshake) checkOutput("bubble_after_grant", 128'(txIf.o_tx_req), 128'(0));
      case (grantMode)
        0:       g = 1'b0;
        1:       g = 1'($urandom_range(0, 1));
        default: g = 1'b1;
      endcase
      txIf.i_tx_grant = g;
      lastHandshake   = txIf.o_tx_req && g;
      if (lastHandshake) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_job actual=req required=no_req at %0t", $time);
        end else begin
          e = expQ.pop_front();
          popCount++;
          checkOutput("tx_job",
            128'({txIf.o_tx_is_cpl, txIf.o_tx_msg_code, txIf.o_tx_cpl_req_id, txIf.o_tx_cpl_tag}),
            128'({e.isCpl, e.code, e.id, e.tag}));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] eType, input logic np, input logic [RID_W-1:0] id,
                               input logic [TAG_W-1:0] tag, input logic [2:0] en);
    @(negedge clk);
    errorCheck = 1'b1;
    errorType  = eType;
    nonposted  = np;
    rxReqId    = id;
    rxReqTag   = tag;
    reportEn   = en;
    hdrFields  = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    errorCheck = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #3;
      if (expQ.size() == 0 && !txIf.o_tx_req) done = 1'b1;
    end
    if (!done) reportTimeout(name);
  endtask

  task automatic waitReq(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      #1;
      if (txIf.o_tx_req) done = 1'b1;
    end
    if (!done) reportTimeout(name);
  endtask

  initial begin
    int popBefore;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_tx_req", 128'(txIf.o_tx_req), 128'(0));
    checkOutput("reset_status", 128'(errStatus), 128'(0));
    checkOutput("reset_log_valid", 128'(hdrLogValid), 128'(0));

    // Fatal error with only fatal reporting enabled; req two cycles after the strobe.
    grantMode = 0;
    applyStimulus(3'd3, 1'b0, '0, '0, 3'b100);
    #1;
    checkOutput("latency_n1_req", 128'(txIf.o_tx_req), 128'(0));
    checkOutput("status3_n1", 128'(errStatus[3]), 128'(1));
    @(negedge clk);
    #1;
    checkOutput("latency_n2_req", 128'(txIf.o_tx_req), 128'(1));
    checkOutput("latency_n2_code", 128'(txIf.o_tx_msg_code), 128'(8'h33));
    grantMode = 2;
    waitDrain("drain_t1");

    // UR on a non-posted request: completion then NONFATAL message.
    grantMode = 1;
    popBefore = popCount;
    applyStimulus(3'd5, 1'b1, 16'h0100, 10'h02A, 3'b010);
    waitDrain("drain_t2");
    checkOutput("t2_job_count", 128'(popCount - popBefore), 128'(2));

    // Reporting disabled: status only, no job.
    applyStimulus(3'd4, 1'b0, '0, '0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput("t3_no_req", 128'(txIf.o_tx_req), 128'(0));
    end

    // Five fatal errors into a depth-4 queue with grant held off.
    grantMode = 0;
    for (int i = 0; i < 5; i++) applyStimulus(3'(1 + i % 3), 1'b0, '0, '0, 3'b100);
    #1;
    checkOutput("t4_overflow", 128'(errStatus[0]), 128'(1));
    popBefore = popCount;
    grantMode = 2;
    waitDrain("drain_t4");
    checkOutput("t4_job_count", 128'(popCount - popBefore), 128'(4));

    // Full queue: a pop frees a slot for a same-cycle push.
    @(negedge clk);
    statusClr = 8'hFF;
    @(negedge clk);
    statusClr = 8'h00;
    grantMode = 0;
    for (int i = 0; i < 4; i++) applyStimulus(3'd2, 1'b0, '0, '0, 3'b100);
    waitReq("t5_req");
    popBefore = popCount;
    @(negedge clk);
    grantMode  = 2;
    errorCheck = 1'b1;
    errorType  = 3'd3;
    reportEn   = 3'b100;
    @(negedge clk);
    errorCheck = 1'b0;
    grantMode  = 0;
    #1;
    checkOutput("t5_no_overflow", 128'(errStatus[0]), 128'(0));
    grantMode = 2;
    waitDrain("drain_t5");
    checkOutput("t5_job_count", 128'(popCount - popBefore), 128'(5));

    // Reset while a job is being requested.
    grantMode = 0;
    applyStimulus(3'd2, 1'b0, '0, '0, 3'b100);
    waitReq("t6_req");
    @(negedge clk);
    #1;
    nRst = 1'b0;
    #1;
    checkOutput("t6_req_async_drop", 128'(txIf.o_tx_req), 128'(0));
    @(negedge clk);
    nRst = 1'b1;
    #1;
    checkOutput("t6_status", 128'(errStatus), 128'(0));
    checkOutput("t6_log_valid", 128'(hdrLogValid), 128'(0));
    checkOutput("t6_log", hdrLog, 128'(0));
    grantMode = 2;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t6_queue_empty", 128'(txIf.o_tx_req), 128'(0));

    // Random traffic, alternating between a random arbiter and a stalled one.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      grantMode  = ((c / 40) % 3 == 2) ? 0 : 1;
      errorCheck = ($urandom_range(0, 99) < 35);
      errorType  = 3'($urandom_range(0, 7));
      nonposted  = 1'($urandom_range(0, 1));
      rxReqId    = 16'($urandom());
      rxReqTag   = 10'($urandom());
      hdrFields  = {$urandom(), $urandom(), $urandom(), $urandom()};
      reportEn   = 3'($urandom_range(0, 7));
      statusClr  = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : 8'h00;
    end
    @(negedge clk);
    errorCheck = 1'b0;
    statusClr  = 8'h00;
    grantMode  = 2;
    waitDrain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
